sync_fifo_prog: RTL and testbench

//  Single-clock FIFO; parametrised successor of the team's dual-clock FIFO, for buffering within one clock domain.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/sync_fifo_ram.sv | 23 ++
 rtl/sync_fifo_prog.sv | 102 ++++++++++
 tb/tb_sync_fifo_prog.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and pointer wrap helper.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Explicit wrap so non-power-of-two depths work.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: synchronous write, asynchronous read.
module sync_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO, any depth, programmable thresholds,
// standard or first-word-fall-through read, sticky errors.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int FWFT  = FIFO_STD,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    input  logic [CNT_W-1:0] af_thresh,
    input  logic [CNT_W-1:0] ae_thresh,
    input  logic             err_clr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] eff_af;
    logic [WIDTH-1:0] ram_rdata;
    logic             rd_acc;
    logic             wr_acc;

    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    assign eff_af       = (af_thresh == '0) ? DEPTH_C : af_thresh;
    assign count        = cnt;
    assign empty        = (cnt == '0);
    assign full         = (cnt == DEPTH_C);
    assign almost_full  = (cnt >= eff_af);
    assign almost_empty = (cnt <= ae_thresh);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= PTR_W'(ptr_inc(int'(wr_ptr), DEPTH));
            if (rd_acc) rd_ptr <= PTR_W'(ptr_inc(int'(rd_ptr), DEPTH));
            unique case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // A new error in the same cycle as err_clr must not be lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & ~wr_acc) overflow <= 1'b1;
            else if (err_clr)    overflow <= 1'b0;
            if (rd_en & ~rd_acc) underflow <= 1'b1;
            else if (err_clr)    underflow <= 1'b0;
        end
    end

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    if (FWFT == FIFO_STD) begin : g_std
        logic [WIDTH-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (rst)         rd_q <= '0;
            else if (rd_acc) rd_q <= ram_rdata;
        end
        assign rd_data = rd_q;
    end else begin : g_fwft
        assign rd_data = empty ? '0 : ram_rdata;
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench: three FIFO variants driven in lockstep
// against a queue-based reference model.
module tb_sync_fifo_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] wr_data;
    logic [4:0] af_a;
    logic [4:0] ae_a;
    logic [3:0] af_b;
    logic [3:0] ae_b;

    logic [7:0] rdd [3];
    logic [4:0] cnt [3];
    logic [3:0] cnt_b;
    logic       fl  [3];
    logic       em  [3];
    logic       afl [3];
    logic       aem [3];
    logic       ovf [3];
    logic       unf [3];

    assign cnt[1] = {1'b0, cnt_b};

    sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rdd[0]), .af_thresh(af_a),
        .ae_thresh(ae_a), .err_clr(err_clr), .count(cnt[0]),
        .full(fl[0]), .empty(em[0]), .almost_full(afl[0]),
        .almost_empty(aem[0]), .overflow(ovf[0]), .underflow(unf[0])
    );

    sync_fifo_prog #(.WIDTH(8), .DEPTH(12), .FWFT(0)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rdd[1]), .af_thresh(af_b),
        .ae_thresh(ae_b), .err_clr(err_clr), .count(cnt_b),
        .full(fl[1]), .empty(em[1]), .almost_full(afl[1]),
        .almost_empty(aem[1]), .overflow(ovf[1]), .underflow(unf[1])
    );

    sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rdd[2]), .af_thresh(af_a),
        .ae_thresh(ae_a), .err_clr(err_clr), .count(cnt[2]),
        .full(fl[2]), .empty(em[2]), .almost_full(afl[2]),
        .almost_empty(aem[2]), .overflow(ovf[2]), .underflow(unf[2])
    );

    int depth [3] = '{16, 12, 16};
    bit fw    [3] = '{1'b0, 1'b0, 1'b1};

    logic [7:0] mq  [3][$];
    logic [7:0] exq [3][$];
    logic [7:0] hold  [3];
    bit         m_ovf [3];
    bit         m_unf [3];
    bit         fire  [3];
    bit         mon_en = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h",
                     nm, i, $time, act, exp);
        end
    endtask

    function automatic int eff_af(input int i);
        int t;
        t = (i == 1) ? int'(af_b) : int'(af_a);
        return (t == 0) ? depth[i] : t;
    endfunction

    function automatic int ae_of(input int i);
        return (i == 1) ? int'(ae_b) : int'(ae_a);
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int         n;
            bit         racc;
            bit         wacc;
            logic [7:0] v;
            if (rst) begin
                mq[i].delete();
                exq[i].delete();
                hold[i]  = 8'h00;
                fire[i]  = 1'b0;
                m_ovf[i] = 1'b0;
                m_unf[i] = 1'b0;
            end else begin
                n    = mq[i].size();
                racc = rd_en && (n > 0);
                wacc = wr_en && ((n < depth[i]) || racc);
                if (racc) begin
                    v = mq[i].pop_front();
                    if (!fw[i]) begin
                        exq[i].push_back(v);
                        fire[i] = 1'b1;
                    end
                end
                if (wacc) mq[i].push_back(wr_data);
                if (wr_en && !wacc) m_ovf[i] = 1'b1;
                else if (err_clr)   m_ovf[i] = 1'b0;
                if (rd_en && !racc) m_unf[i] = 1'b1;
                else if (err_clr)   m_unf[i] = 1'b0;
            end
        end
        mon_en = 1'b1;
    endtask

    task automatic cyc(input logic r, input logic w, input logic rd,
                       input logic [7:0] d, input logic ec);
        rst     = r;
        wr_en   = w;
        rd_en   = rd;
        wr_data = d;
        err_clr = ec;
        @(posedge clk);
        #2;
        model_step();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                int n;
                n = mq[i].size();
                chk("count", i, cnt[i], n);
                chk("full", i, fl[i], n == depth[i]);
                chk("empty", i, em[i], n == 0);
                chk("almost_full", i, afl[i], n >= eff_af(i));
                chk("almost_empty", i, aem[i], n <= ae_of(i));
                chk("overflow", i, ovf[i], m_ovf[i]);
                chk("underflow", i, unf[i], m_unf[i]);
                if (fw[i]) begin
                    chk("rd_data_fwft", i, rdd[i],
                        (n > 0) ? mq[i][0] : 8'h00);
                end else begin
                    if (fire[i]) begin
                        fire[i] = 1'b0;
                        if (exq[i].size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL scoreboard inst%0d: no entry", i);
                        end else begin
                            hold[i] = exq[i].pop_front();
                        end
                    end
                    chk("rd_data", i, rdd[i], hold[i]);
                end
            end
        end
    end

    initial begin
        int pw;
        int pr;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        wr_data = 8'h00; err_clr = 1'b0;
        af_a = 5'd14; ae_a = 5'd2; af_b = 4'd10; ae_b = 4'd2;

        cyc(1, 0, 0, 8'h00, 0);
        cyc(1, 0, 0, 8'h00, 0);
        for (int k = 0; k < 17; k++) cyc(0, 1, 0, 8'(k), 0);
        cyc(0, 0, 0, 8'h00, 1);
        for (int k = 0; k < 17; k++) cyc(0, 0, 1, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 1);

        for (int k = 0; k < 16; k++) cyc(0, 1, 0, 8'(8'h40 + k), 0);
        for (int k = 0; k < 5; k++)  cyc(0, 1, 1, 8'(8'h80 + k), 0);
        for (int k = 0; k < 16; k++) cyc(0, 0, 1, 8'h00, 0);
        cyc(0, 1, 1, 8'hA5, 0);
        cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 1, 8'h00, 1);

        ae_a = 5'd3; af_a = 5'd0; ae_b = 4'd3; af_b = 4'd0;
        for (int k = 0; k < 17; k++) cyc(0, 1, 0, 8'(8'hC0 + k), 0);
        for (int k = 0; k < 8; k++)  cyc(0, 0, 1, 8'h00, 0);
        cyc(1, 1, 1, 8'h11, 0);
        cyc(0, 0, 0, 8'h00, 0);

        for (int b = 0; b < 30; b++) begin
            if (b % 5 == 0) begin
                af_a = 5'($urandom_range(0, 16));
                ae_a = 5'($urandom_range(0, 16));
                af_b = 4'($urandom_range(0, 12));
                ae_b = 4'($urandom_range(0, 12));
            end
            pw = $urandom_range(20, 80);
            pr = $urandom_range(20, 80);
            for (int k = 0; k < 100; k++) begin
                cyc($urandom_range(0, 299) == 0,
                    $urandom_range(0, 99) < pw,
                    $urandom_range(0, 99) < pr,
                    8'($urandom),
                    $urandom_range(0, 19) == 0);
            end
        end
        cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 0);
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("scoreboard_drained", i, exq[i].size(), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
